// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and FSM encoding for the pipeline stall/flush controller.
// No logic; imported by pipe_stall_ctrl and its down-counter.
// Stall vectors are one bit per pipeline register, 1 = hold.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RUN  = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_down_cnt.sv
// Multi-cycle op down-counter: clear beats load beats decrement.
// Latency: new value visible one cycle after the control strobe.
// No backpressure; the controller decides when to load or decrement.
module pipe_stall_ctrl_mc_down_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller with multi-cycle EX sequencing.
// Latency: stall/flush are combinational from requests and current FSM state.
// Backpressure: mem stall holds all but wb; counter still runs under mem stall.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stall_req,
  input  logic               ex_mc_start,
  input  logic [CNT_W-1:0]   ex_mc_len,
  input  logic               mem_stall_req,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               ex_mc_busy,
  output logic               ex_mc_done
);

  mc_state_e        state;
  mc_state_e        next_state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one;
  logic             len_ge2;
  logic             accept;
  logic             ex_stall;

  assign len_ge2 = (ex_mc_len >= CNT_W'(2));
  // A start is only taken from IDLE; flush in the same cycle kills it.
  assign accept  = (state == MC_IDLE) && ex_mc_start && len_ge2 && !flush_req;

  pipe_stall_ctrl_mc_down_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_req),
    .load     (accept),
    .dec      (state == MC_RUN),
    .load_val (ex_mc_len - CNT_W'(2)),
    .cnt      (cnt),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      MC_IDLE: begin
        if (accept) begin
          next_state = (ex_mc_len == CNT_W'(2)) ? MC_DONE : MC_RUN;
        end
      end
      MC_RUN: begin
        if (cnt_is_one) begin
          next_state = MC_DONE;
        end
      end
      MC_DONE: begin
        if (!mem_stall_req) begin
          next_state = MC_IDLE;
        end
      end
      default: next_state = MC_IDLE;
    endcase
    if (flush_req) begin
      next_state = MC_IDLE;
    end
  end

  always_comb begin
    ex_stall   = (state == MC_RUN) ||
                 ((state == MC_IDLE) && ex_mc_start && len_ge2);
    stall      = STALL_NONE;
    flush      = 1'b0;
    ex_mc_busy = 1'b0;
    ex_mc_done = 1'b0;
    if (!rst) begin
      ex_mc_busy = (state == MC_RUN) || accept;
      ex_mc_done = (state == MC_DONE);
      if (flush_req) begin
        flush = 1'b1;
      end else if (mem_stall_req) begin
        stall = STALL_MEM;
      end else if (ex_stall) begin
        stall = STALL_EX;
      end else if (id_stall_req) begin
        stall = STALL_ID;
      end
    end
  end

endmodule
